phy_tx_monitor_8b: RTL and testbench

PHY-emulator-side GMII transmit receiver. It consumes the 8-bit GMII TX stream driven by the MAC under test and decodes each frame: start/terminate characters, preamble/SFD check, FCS stripping, CRC-32 check and length check. It emits the payload as a byte stream with frame status and running counters. It is the counterpart of the emulator's RX-generation path and sits beside it in the PHY emulator, on the same clock.

---
 rtl/phy_emu_pkg.sv | 40 ++++
 rtl/crc32_d8.sv | 17 +
 rtl/phy_tx_monitor_8b.sv | 246 ++++++++++++++++++++++++
 tb/tb_phy_tx_monitor_8b.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_emu_pkg.sv
// Shared constants and types for the PHY emulator: GMII control characters,
// CRC-32 parameters, speed codes and the TX-monitor state enum.
package phy_emu_pkg;

  localparam logic [7:0] CH_START = 8'hFB;
  localparam logic [7:0] CH_TERM  = 8'hFD;
  localparam logic [7:0] CH_IDLE  = 8'h07;
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam int DLY_DEPTH = 5;

  typedef enum logic [1:0] {
    SPD_OFF  = 2'b00,
    SPD_1G   = 2'b01,
    SPD_100M = 2'b10,
    SPD_10M  = 2'b11
  } speed_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_DROP
  } state_e;

  // Terminal count of the sample divider; strobe fires when the divider is 0.
  function automatic logic [7:0] div_limit(input logic [1:0] spd);
    case (spd)
      SPD_100M: return 8'd9;
      SPD_10M:  return 8'd99;
      default:  return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update for one byte (LSB first, no final XOR).
module crc32_d8
  import phy_emu_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  always_comb begin
    o_crc = i_crc ^ {24'h0, i_data};
    for (int b = 0; b < 8; b++) begin
      o_crc = o_crc[0] ? ((o_crc >> 1) ^ CRC_POLY) : (o_crc >> 1);
    end
  end

endmodule

// File: rtl/phy_tx_monitor_8b.sv
// GMII TX frame decoder for the PHY emulator: preamble/SFD check, FCS strip,
// CRC/length check, status pulses and counters. Optional PHY_TX_MON_LOG_EN adds sim logging.
module phy_tx_monitor_8b
  import phy_emu_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        xaui_clk,
  input  logic        reset,
  input  logic [1:0]  fmac_speed,
  input  logic [7:0]  gmii_txd,
  input  logic        gmii_txc,
  input  logic        gmii_tx_en,
  input  logic        gmii_tx_vld,
  output logic [7:0]  rx_data,
  output logic        rx_data_vld,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_good,
  output logic        rx_bad,
  output logic [10:0] frame_len,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt,
  output logic        busy
);

  localparam logic [10:0] LEN_MIN     = 11'(MIN_LEN);
  localparam logic [10:0] LEN_MAX     = 11'(MAX_LEN);
  localparam logic [10:0] LEN_SAT     = 11'h7FF;
  localparam logic [2:0]  PRE_CNT_SFD = 3'd6;
  localparam logic [2:0]  FILL_FULL   = 3'(DLY_DEPTH);

  logic        w_unused_txc;
  logic [1:0]  r_rst_sync;
  logic        w_run;
  logic [1:0]  r_speed;
  logic [7:0]  r_div;
  logic        w_div_clr;
  logic        w_strobe;
  logic        w_spd_chg;
  logic        w_start;
  logic        w_term;
  state_e      r_state, w_state_nxt;
  logic [2:0]  r_pre_cnt, w_pre_cnt_nxt;
  logic [31:0] r_crc, w_crc_nxt, w_crc_byte;
  logic [10:0] r_len, w_len_nxt, w_len_inc;
  logic [2:0]  r_fill, w_fill_nxt;
  logic        r_sof_pend, w_sof_pend_nxt;
  logic [7:0]  r_dly [DLY_DEPTH];
  logic        w_push, w_emit, w_eof, w_good;

  assign w_unused_txc = gmii_txc;

  // Reset asserts immediately; release is held off two clocks so the
  // datapath never leaves reset on a metastable edge.
  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) r_rst_sync <= 2'b00;
    else       r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_run = r_rst_sync[1];

  assign w_start   = gmii_tx_en & gmii_tx_vld & (gmii_txd == CH_START);
  assign w_term    = gmii_tx_vld & (gmii_txd == CH_TERM);
  assign w_spd_chg = w_run & (fmac_speed != r_speed) & (r_state != ST_IDLE);
  assign w_len_inc = (r_len == LEN_SAT) ? r_len : r_len + 11'd1;

  always_comb begin
    w_strobe = 1'b0;
    if (w_run) begin
      case (fmac_speed)
        SPD_1G:           w_strobe = 1'b1;
        SPD_100M, SPD_10M: w_strobe = (r_div == 8'd0);
        default:          w_strobe = 1'b0;
      endcase
    end
  end

  // Holding the divider at 0 in IDLE makes the FB cycle the sampling phase
  // for the rest of the frame's replicated bytes.
  assign w_div_clr = !w_run || (fmac_speed == SPD_1G) || (fmac_speed == SPD_OFF) ||
                     (fmac_speed != r_speed) || ((r_state == ST_IDLE) && !w_start);

  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) begin
      r_speed <= 2'b00;
      r_div   <= 8'd0;
    end else begin
      r_speed <= fmac_speed;
      if (w_div_clr || (r_div == div_limit(fmac_speed))) r_div <= 8'd0;
      else                                              r_div <= r_div + 8'd1;
    end
  end

  crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (gmii_txd),
    .o_crc  (w_crc_byte)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_pre_cnt_nxt  = r_pre_cnt;
    w_crc_nxt      = r_crc;
    w_len_nxt      = r_len;
    w_fill_nxt     = r_fill;
    w_sof_pend_nxt = r_sof_pend;
    w_push         = 1'b0;
    w_emit         = 1'b0;
    w_eof          = 1'b0;
    w_good         = 1'b0;
    if (w_spd_chg) begin
      w_eof       = (r_state == ST_PRE) || (r_state == ST_DATA);
      w_state_nxt = (fmac_speed == SPD_OFF) ? ST_IDLE : ST_DROP;
    end else if (w_strobe) begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            w_state_nxt   = ST_PRE;
            w_pre_cnt_nxt = 3'd0;
            w_len_nxt     = 11'd0;
          end
        end
        ST_PRE: begin
          if (gmii_tx_en && !gmii_tx_vld && (gmii_txd == PRE_BYTE) &&
              (r_pre_cnt != PRE_CNT_SFD)) begin
            w_pre_cnt_nxt = r_pre_cnt + 3'd1;
          end else if (gmii_tx_en && !gmii_tx_vld && (gmii_txd == SFD_BYTE) &&
                       (r_pre_cnt == PRE_CNT_SFD)) begin
            w_state_nxt    = ST_DATA;
            w_crc_nxt      = CRC_INIT;
            w_len_nxt      = 11'd0;
            w_fill_nxt     = 3'd0;
            w_sof_pend_nxt = 1'b1;
          end else begin
            w_eof       = 1'b1;
            w_state_nxt = ST_DROP;
          end
        end
        ST_DATA: begin
          if (!gmii_tx_en || (gmii_tx_vld && !w_term)) begin
            w_eof       = 1'b1;
            w_state_nxt = ST_DROP;
          end else if (w_term) begin
            w_eof       = 1'b1;
            w_good      = (r_crc == CRC_RESIDUE) && (r_len >= LEN_MIN) && (r_len <= LEN_MAX);
            w_emit      = (r_fill == FILL_FULL);
            w_state_nxt = ST_IDLE;
          end else begin
            w_push    = 1'b1;
            w_crc_nxt = w_crc_byte;
            w_len_nxt = w_len_inc;
            if (r_fill == FILL_FULL) w_emit = 1'b1;
            else                     w_fill_nxt = r_fill + 3'd1;
          end
        end
        ST_DROP: begin
          if (!gmii_tx_en || w_term) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    if (w_emit) w_sof_pend_nxt = 1'b0;
  end

  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pre_cnt  <= 3'd0;
      r_crc      <= 32'd0;
      r_len      <= 11'd0;
      r_fill     <= 3'd0;
      r_sof_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pre_cnt  <= w_pre_cnt_nxt;
      r_crc      <= w_crc_nxt;
      r_len      <= w_len_nxt;
      r_fill     <= w_fill_nxt;
      r_sof_pend <= w_sof_pend_nxt;
    end
  end

  // Five-byte delay line hides the 4-byte FCS: what remains at FD is FCS.
  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DLY_DEPTH; i++) r_dly[i] <= 8'd0;
    end else if (w_push) begin
      for (int i = DLY_DEPTH - 1; i > 0; i--) r_dly[i] <= r_dly[i-1];
      r_dly[0] <= gmii_txd;
    end
  end

  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) begin
      rx_data     <= 8'd0;
      rx_data_vld <= 1'b0;
      rx_sof      <= 1'b0;
      rx_eof      <= 1'b0;
      rx_good     <= 1'b0;
      rx_bad      <= 1'b0;
      frame_len   <= 11'd0;
      pkt_cnt     <= 16'd0;
      err_cnt     <= 16'd0;
      busy        <= 1'b0;
    end else begin
      rx_data_vld <= w_emit;
      rx_sof      <= w_emit & r_sof_pend;
      rx_eof      <= w_eof;
      rx_good     <= w_eof & w_good;
      rx_bad      <= w_eof & ~w_good;
      busy        <= (w_state_nxt != ST_IDLE);
      if (w_emit) rx_data <= r_dly[DLY_DEPTH-1];
      if (w_eof) begin
        frame_len <= r_len;
        if (w_good) pkt_cnt <= pkt_cnt + 16'd1;
        else        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

`ifdef PHY_TX_MON_LOG_EN
  bit     r_log_open = 1'b0;
  integer r_log_pkt  = 0;
  integer r_log_idx  = 0;

  always @(posedge xaui_clk) begin
    if (w_strobe) begin
      if ((r_state == ST_IDLE) && w_start) begin
        r_log_pkt  = r_log_pkt + 1;
        r_log_idx  = 0;
        r_log_open = 1'b1;
        $display("data # packet %0d", r_log_pkt);
        $display("ctrl # packet %0d", r_log_pkt);
      end
      if (r_log_open) begin
        $display("data %0d %0d %02h", r_log_pkt, r_log_idx, gmii_txd);
        $display("ctrl %0d %0d %0b", r_log_pkt, r_log_idx, gmii_tx_vld);
        r_log_idx = r_log_idx + 1;
        if (w_term) r_log_open = 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_phy_tx_monitor_8b.sv
// Directed bench for phy_tx_monitor_8b: frames built with a bench-side CRC-32
// model, driven at 1G/100M/10M, with outputs sampled 1 time unit after each edge.
module tb_phy_tx_monitor_8b;

  logic        xaui_clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  fmac_speed = 2'b01;
  logic [7:0]  gmii_txd = 8'h07;
  logic        gmii_txc = 1'b0;
  logic        gmii_tx_en = 1'b0;
  logic        gmii_tx_vld = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_data_vld, rx_sof, rx_eof, rx_good, rx_bad, busy;
  logic [10:0] frame_len;
  logic [15:0] pkt_cnt, err_cnt;

  always #5 xaui_clk = ~xaui_clk;

  phy_tx_monitor_8b dut (
    .xaui_clk    (xaui_clk),
    .reset       (reset),
    .fmac_speed  (fmac_speed),
    .gmii_txd    (gmii_txd),
    .gmii_txc    (gmii_txc),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_vld (gmii_tx_vld),
    .rx_data     (rx_data),
    .rx_data_vld (rx_data_vld),
    .rx_sof      (rx_sof),
    .rx_eof      (rx_eof),
    .rx_good     (rx_good),
    .rx_bad      (rx_bad),
    .frame_len   (frame_len),
    .pkt_cnt     (pkt_cnt),
    .err_cnt     (err_cnt),
    .busy        (busy)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] pay [0:127];
  logic [9:0] sym_q [$];
  int t_pay0 = 0;

  int cyc = 0;
  int mon_vld_cnt, mon_sof_cnt, mon_sof_idx, mon_eof_cnt, mon_good_cnt, mon_bad_cnt;
  int mon_first_cyc, mon_last_cyc, mon_gap_min, mon_gap_max;
  logic mon_eof_vld;
  logic [7:0] mon_bytes [0:255];

  always @(posedge xaui_clk) begin
    #1;
    cyc = cyc + 1;
    if (rx_data_vld === 1'b1) begin
      if (mon_vld_cnt < 256) mon_bytes[mon_vld_cnt] = rx_data;
      if (mon_vld_cnt == 0) mon_first_cyc = cyc;
      else begin
        if (cyc - mon_last_cyc < mon_gap_min) mon_gap_min = cyc - mon_last_cyc;
        if (cyc - mon_last_cyc > mon_gap_max) mon_gap_max = cyc - mon_last_cyc;
      end
      mon_last_cyc = cyc;
      if (rx_sof === 1'b1) mon_sof_idx = mon_vld_cnt;
      mon_vld_cnt = mon_vld_cnt + 1;
    end
    if (rx_sof === 1'b1) mon_sof_cnt = mon_sof_cnt + 1;
    if (rx_eof === 1'b1) begin
      mon_eof_cnt = mon_eof_cnt + 1;
      mon_eof_vld = rx_data_vld;
    end
    if (rx_good === 1'b1) mon_good_cnt = mon_good_cnt + 1;
    if (rx_bad === 1'b1)  mon_bad_cnt  = mon_bad_cnt + 1;
  end

  // Bit-serial reflected CRC-32 reference.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic fill_payload(input int seed);
    for (int i = 0; i < 128; i++) pay[i] = 8'((i * 37 + seed) & 255);
  endtask

  task automatic build_frame(input int n, input bit flip_fcs, input bit bad_pre, input int cut_after);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    sym_q.delete();
    sym_q.push_back({1'b1, 1'b1, 8'hFB});
    for (int i = 0; i < 6; i++) sym_q.push_back({1'b1, 1'b0, ((bad_pre && i == 0) ? 8'h54 : 8'h55)});
    sym_q.push_back({1'b1, 1'b0, 8'hD5});
    for (int i = 0; i < n; i++) begin
      sym_q.push_back({1'b1, 1'b0, pay[i]});
      c = crc_upd(c, pay[i]);
      if (cut_after == i + 1) begin
        for (int k = 0; k < 3; k++) sym_q.push_back({1'b0, 1'b1, 8'h07});
        return;
      end
    end
    c = ~c;
    for (int k = 0; k < 4; k++) begin
      b = c[8*k +: 8];
      if (flip_fcs && k == 0) b[0] = ~b[0];
      sym_q.push_back({1'b1, 1'b0, b});
    end
    sym_q.push_back({1'b1, 1'b1, 8'hFD});
    for (int k = 0; k < 3; k++) sym_q.push_back({1'b0, 1'b1, 8'h07});
  endtask

  task automatic drive_syms(input int hold, input int count);
    for (int i = 0; i < count && i < sym_q.size(); i++) begin
      @(negedge xaui_clk);
      {gmii_tx_en, gmii_tx_vld, gmii_txd} = sym_q[i];
      if (i == 8) t_pay0 = cyc;
      repeat (hold - 1) @(negedge xaui_clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge xaui_clk);
      gmii_tx_en = 1'b0; gmii_tx_vld = 1'b1; gmii_txd = 8'h07;
    end
  endtask

  task automatic clear_mon();
    @(negedge xaui_clk);
    mon_vld_cnt = 0; mon_sof_cnt = 0; mon_sof_idx = -1; mon_eof_cnt = 0;
    mon_good_cnt = 0; mon_bad_cnt = 0; mon_first_cyc = 0; mon_last_cyc = 0;
    mon_gap_min = 1000000; mon_gap_max = 0; mon_eof_vld = 1'b0;
  endtask

  task automatic run_frame(input int hold);
    clear_mon();
    drive_syms(hold, sym_q.size());
    for (int t = 0; t < 20 * hold && mon_eof_cnt == 0; t++) @(negedge xaui_clk);
    idle(2);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    repeat (3) @(negedge xaui_clk);
    checks++; if ({rx_data_vld, rx_sof, rx_eof, rx_good, rx_bad, busy} !== 6'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 000000", {rx_data_vld, rx_sof, rx_eof, rx_good, rx_bad, busy}); end
    checks++; if ({rx_data, frame_len, pkt_cnt, err_cnt} !== 51'd0) begin
      failures++; $display("FAIL reset_values: got data=%0h len=%0d pkt=%0d err=%0d expected all 0", rx_data, frame_len, pkt_cnt, err_cnt); end
    reset = 1'b0;
    idle(5);
  endtask

  task automatic test_good_1g();
    fill_payload(3);
    build_frame(60, 1'b0, 1'b0, -1);
    run_frame(1);
    checks++; if (mon_vld_cnt !== 60) begin failures++; $display("FAIL g1_vld_cnt: got %0d expected 60", mon_vld_cnt); end
    for (int i = 0; i < 60; i++) begin
      checks++; if (mon_bytes[i] !== pay[i]) begin failures++; $display("FAIL g1_byte%0d: got %02h expected %02h", i, mon_bytes[i], pay[i]); end
    end
    checks++; if (mon_sof_cnt !== 1 || mon_sof_idx !== 0) begin failures++; $display("FAIL g1_sof: got cnt=%0d idx=%0d expected cnt=1 idx=0", mon_sof_cnt, mon_sof_idx); end
    checks++; if (mon_eof_cnt !== 1 || mon_good_cnt !== 1 || mon_bad_cnt !== 0) begin
      failures++; $display("FAIL g1_status: got eof=%0d good=%0d bad=%0d expected 1 1 0", mon_eof_cnt, mon_good_cnt, mon_bad_cnt); end
    checks++; if (mon_eof_vld !== 1'b1) begin failures++; $display("FAIL g1_eof_on_last_byte: got %b expected 1", mon_eof_vld); end
    checks++; if (mon_first_cyc - t_pay0 !== 6) begin failures++; $display("FAIL g1_latency: got %0d expected 6", mon_first_cyc - t_pay0); end
    checks++; if (frame_len !== 11'd64) begin failures++; $display("FAIL g1_frame_len: got %0d expected 64", frame_len); end
    checks++; if (pkt_cnt !== 16'd1 || err_cnt !== 16'd0) begin failures++; $display("FAIL g1_counters: got pkt=%0d err=%0d expected 1 0", pkt_cnt, err_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL g1_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_bad_fcs();
    build_frame(60, 1'b1, 1'b0, -1);
    run_frame(1);
    checks++; if (mon_eof_cnt !== 1 || mon_good_cnt !== 0 || mon_bad_cnt !== 1) begin
      failures++; $display("FAIL fcs_status: got eof=%0d good=%0d bad=%0d expected 1 0 1", mon_eof_cnt, mon_good_cnt, mon_bad_cnt); end
    checks++; if (pkt_cnt !== 16'd1 || err_cnt !== 16'd1) begin failures++; $display("FAIL fcs_counters: got pkt=%0d err=%0d expected 1 1", pkt_cnt, err_cnt); end
    checks++; if (mon_vld_cnt !== 60) begin failures++; $display("FAIL fcs_vld_cnt: got %0d expected 60", mon_vld_cnt); end
  endtask

  task automatic test_slow_speeds();
    @(negedge xaui_clk); fmac_speed = 2'b10;
    idle(5);
    fill_payload(11);
    build_frame(60, 1'b0, 1'b0, -1);
    run_frame(10);
    checks++; if (mon_vld_cnt !== 60) begin failures++; $display("FAIL m100_vld_cnt: got %0d expected 60", mon_vld_cnt); end
    for (int i = 0; i < 60; i++) begin
      checks++; if (mon_bytes[i] !== pay[i]) begin failures++; $display("FAIL m100_byte%0d: got %02h expected %02h", i, mon_bytes[i], pay[i]); end
    end
    checks++; if (mon_gap_min !== 10 || mon_gap_max !== 10) begin failures++; $display("FAIL m100_gap: got min=%0d max=%0d expected 10 10", mon_gap_min, mon_gap_max); end
    checks++; if (mon_first_cyc - t_pay0 !== 51) begin failures++; $display("FAIL m100_latency: got %0d expected 51", mon_first_cyc - t_pay0); end
    checks++; if (mon_good_cnt !== 1 || mon_bad_cnt !== 0 || pkt_cnt !== 16'd2) begin
      failures++; $display("FAIL m100_status: got good=%0d bad=%0d pkt=%0d expected 1 0 2", mon_good_cnt, mon_bad_cnt, pkt_cnt); end
    @(negedge xaui_clk); fmac_speed = 2'b11;
    idle(5);
    run_frame(100);
    checks++; if (mon_vld_cnt !== 60) begin failures++; $display("FAIL m10_vld_cnt: got %0d expected 60", mon_vld_cnt); end
    checks++; if (mon_gap_min !== 100 || mon_gap_max !== 100) begin failures++; $display("FAIL m10_gap: got min=%0d max=%0d expected 100 100", mon_gap_min, mon_gap_max); end
    checks++; if (mon_good_cnt !== 1 || mon_bad_cnt !== 0 || pkt_cnt !== 16'd3) begin
      failures++; $display("FAIL m10_status: got good=%0d bad=%0d pkt=%0d expected 1 0 3", mon_good_cnt, mon_bad_cnt, pkt_cnt); end
    @(negedge xaui_clk); fmac_speed = 2'b01;
    idle(5);
  endtask

  task automatic test_abort_en();
    fill_payload(29);
    build_frame(60, 1'b0, 1'b0, 20);
    run_frame(1);
    checks++; if (mon_eof_cnt !== 1 || mon_bad_cnt !== 1 || mon_good_cnt !== 0) begin
      failures++; $display("FAIL abort_status: got eof=%0d bad=%0d good=%0d expected 1 1 0", mon_eof_cnt, mon_bad_cnt, mon_good_cnt); end
    checks++; if (mon_vld_cnt !== 15) begin failures++; $display("FAIL abort_vld_cnt: got %0d expected 15", mon_vld_cnt); end
    checks++; if (frame_len !== 11'd20 || err_cnt !== 16'd2) begin failures++; $display("FAIL abort_len_err: got len=%0d err=%0d expected 20 2", frame_len, err_cnt); end
    build_frame(60, 1'b0, 1'b0, -1);
    run_frame(1);
    checks++; if (mon_good_cnt !== 1 || mon_bad_cnt !== 0 || pkt_cnt !== 16'd4) begin
      failures++; $display("FAIL after_abort: got good=%0d bad=%0d pkt=%0d expected 1 0 4", mon_good_cnt, mon_bad_cnt, pkt_cnt); end
  endtask

  task automatic test_bad_pre_and_short();
    fill_payload(41);
    build_frame(60, 1'b0, 1'b1, -1);
    run_frame(1);
    checks++; if (mon_eof_cnt !== 1 || mon_bad_cnt !== 1 || mon_vld_cnt !== 0) begin
      failures++; $display("FAIL pre_status: got eof=%0d bad=%0d vld=%0d expected 1 1 0", mon_eof_cnt, mon_bad_cnt, mon_vld_cnt); end
    checks++; if (frame_len !== 11'd0 || err_cnt !== 16'd3) begin failures++; $display("FAIL pre_len_err: got len=%0d err=%0d expected 0 3", frame_len, err_cnt); end
    build_frame(59, 1'b0, 1'b0, -1);
    run_frame(1);
    checks++; if (mon_bad_cnt !== 1 || mon_good_cnt !== 0 || mon_vld_cnt !== 59) begin
      failures++; $display("FAIL len63_status: got bad=%0d good=%0d vld=%0d expected 1 0 59", mon_bad_cnt, mon_good_cnt, mon_vld_cnt); end
    checks++; if (frame_len !== 11'd63 || err_cnt !== 16'd4 || pkt_cnt !== 16'd4) begin
      failures++; $display("FAIL len63_counters: got len=%0d err=%0d pkt=%0d expected 63 4 4", frame_len, err_cnt, pkt_cnt); end
    build_frame(0, 1'b0, 1'b0, -1);
    run_frame(1);
    checks++; if (mon_eof_cnt !== 1 || mon_bad_cnt !== 1 || mon_vld_cnt !== 0 || mon_sof_cnt !== 0) begin
      failures++; $display("FAIL tiny_status: got eof=%0d bad=%0d vld=%0d sof=%0d expected 1 1 0 0", mon_eof_cnt, mon_bad_cnt, mon_vld_cnt, mon_sof_cnt); end
    checks++; if (frame_len !== 11'd4 || err_cnt !== 16'd5) begin failures++; $display("FAIL tiny_len_err: got len=%0d err=%0d expected 4 5", frame_len, err_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    fill_payload(57);
    build_frame(60, 1'b0, 1'b0, -1);
    clear_mon();
    drive_syms(1, 38);
    @(negedge xaui_clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b expected 1", busy); end
    reset = 1'b1;
    #1;
    checks++; if ({rx_data_vld, rx_sof, rx_eof, rx_good, rx_bad, busy} !== 6'b0 ||
                  {rx_data, frame_len, pkt_cnt, err_cnt} !== 51'd0) begin
      failures++; $display("FAIL mid_reset_outputs: got flags=%b len=%0d pkt=%0d err=%0d expected all 0",
                           {rx_data_vld, rx_sof, rx_eof, rx_good, rx_bad, busy}, frame_len, pkt_cnt, err_cnt); end
    idle(3);
    reset = 1'b0;
    idle(6);
    checks++; if (mon_eof_cnt !== 0) begin failures++; $display("FAIL mid_no_eof: got %0d expected 0", mon_eof_cnt); end
    run_frame(1);
    checks++; if (mon_good_cnt !== 1 || mon_vld_cnt !== 60 || pkt_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      failures++; $display("FAIL post_reset_frame: got good=%0d vld=%0d pkt=%0d err=%0d expected 1 60 1 0",
                           mon_good_cnt, mon_vld_cnt, pkt_cnt, err_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_1g();
    test_bad_fcs();
    test_slow_speeds();
    test_abort_en();
    test_bad_pre_and_short();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
